spi_wb_sequencer: RTL and testbench
===================================

// Module: spi_wb_sequencer
// PURPOSE
// Wishbone master sitting directly upstream of the SPI master's Wishbone slave (CONFIG/DATA registers).
// Converts one host command (tx_len bytes out, then rx_len bytes in) into CONFIG/DATA bus cycles.
// Polls the busy flag and streams received bytes back to the host. Chip select is held low for the whole command.
// PARAMETERS
// BASE_ADR   32'h2400_0000  SPI master base address
// CFG_OFS    32'h0          CONFIG register offset
// DATA_OFS   32'h4          DATA register offset
// PRESCALE   8'd2           CONFIG[7:0] prescaler value
// TIMEOUT    16'd1023       max wait cycles for ack, per bus cycle
// PORTS
// wb_clk_i    in   1   clock
// wb_rst_ni   in   1   asynchronous active-low reset
// cmd_valid   in   1   command request
// cmd_ready   out  1   high in IDLE only
// cmd_txlen   in   8   bytes to send (0..255)
// cmd_rxlen   in   8   bytes to receive (0..255)
// tx_data     in   8   tx byte; tx_valid in 1; tx_ready out 1
// rx_data     out  8   rx byte; rx_valid out 1; rx_ready in 1
// busy        out  1   command in progress
// err         out  1   sticky ack-timeout flag, cleared by next accepted command
// wbm_cyc_o, wbm_stb_o, wbm_we_o  out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32
// wbm_dat_i   in   32  read data; wbm_ack_i in 1
// BEHAVIOUR
// Reset: all outputs 0 (cmd_ready=1 once reset is released); FSM in IDLE; counters 0.
// Slave contract: CONFIG bits are [7:0] prescale, [12] stream, [13] enable. A DATA write of [7:0] starts a byte.
//   A DATA read returns [7:0] the last rx byte and [8] busy.
// Bus: single cycle outstanding. cyc/stb/we/adr/dat are registered and stable until the ack cycle; they drop on the cycle after the ack.
//   sel=4'hF always. The cycle-after-ack gap also applies between back-to-back cycles.
// FSM:
//   IDLE: cmd_valid&cmd_ready latches lengths and clears err.
//     Both lengths 0: pulse through DONE with no bus activity.
//     Otherwise go to CFG_ON.
//   CFG_ON: write CONFIG = PRESCALE | stream | enable.
//   TX_GET: if tx_cnt<txlen, wait for tx_valid, take the byte (tx_ready high one cycle), then go to TX_WR.
//     Else if rx_cnt<rxlen, use byte 8'h00, then go to TX_WR.
//     Else go to CFG_OFF.
//   TX_WR: write DATA = {24'd0, byte}.
//   POLL: read DATA; repeat while rd[8]=1.
//     When not busy: in tx phase, tx_cnt++ (rx byte discarded) and go to TX_GET; in rx phase, go to RX_PUT.
//   RX_PUT: rx_valid=1 with rx_data=rd[7:0] held until rx_ready, then rx_cnt++ and go to TX_GET.
//   CFG_OFF: write CONFIG = PRESCALE | enable (stream=0 releases CSB).
//   DONE: one cycle, then IDLE.
// busy=1 in every state except IDLE.
// Counters are 8-bit, compared against latched lengths; no wrap (max 255).
// Timeout: a counter starts at stb assertion. Reaching TIMEOUT with no ack drops cyc/stb, sets err, and goes to IDLE without CFG_OFF.
// Inputs are ignored while not requested: cmd_valid outside IDLE, tx_valid outside TX_GET.
// Async reset mid-command: bus signals drop immediately; any partial transfer is abandoned.
// TESTING
// Reset: assert wb_rst_ni=0 mid-command -> cyc/stb/busy/rx_valid=0 same cycle, cmd_ready=1 after release.
// txlen=2 (A5,3C), rxlen=0 -> bus sequence: W CFG=0x3002, W DATA=A5, R polls, W DATA=3C, R polls, W CFG=0x2002; done.
// txlen=1 (9F), rxlen=3, slave model returns EF,40,18 -> three W DATA=00, rx stream EF,40,18; byte read during 9F discarded.
// Slave busy=1 for 5 reads, then 0 -> exactly 6 DATA reads per byte; no extra write.
// rx_ready held low 20 cycles -> rx_valid/rx_data stable, no bus cycles until accepted.
// No ack on CONFIG write -> cyc drops after TIMEOUT cycles, err=1, IDLE; next command clears err.

Source files
------------

// File: rtl/spi_wb_sequencer.sv
// rtl/spi_wb_sequencer.sv - Wishbone master turning one host command into SPI master CONFIG/DATA bus cycles
module spi_wb_sequencer #(
    parameter logic [31:0] BASE_ADR = 32'h2400_0000,
    parameter logic [31:0] CFG_OFS  = 32'h0,
    parameter logic [31:0] DATA_OFS = 32'h4,
    parameter logic [7:0]  PRESCALE = 8'd2,
    parameter logic [15:0] TIMEOUT  = 16'd1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_txlen,
    input  logic [7:0]  cmd_rxlen,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_ON, S_TX_GET, S_TX_WR, S_POLL, S_RX_PUT, S_CFG_OFF, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_txlen, r_rxlen, r_tx_cnt, r_rx_cnt, r_byte, r_rx_data;
    logic        r_err, r_cyc, r_we, r_live;
    logic [31:0] r_adr, r_dat;
    logic [15:0] r_tmo;

    logic        w_accept, w_tx_more, w_rx_more, w_bus_state, w_start, w_ack, w_tmo, w_rd_busy;
    logic        w_req_we;
    logic [31:0] w_req_adr, w_req_dat;
    logic        w_unused;

    assign w_accept    = cmd_valid & cmd_ready;
    assign w_tx_more   = r_tx_cnt < r_txlen;
    assign w_rx_more   = r_rx_cnt < r_rxlen;
    assign w_bus_state = (r_state == S_CFG_ON) || (r_state == S_TX_WR) ||
                         (r_state == S_POLL)   || (r_state == S_CFG_OFF);
    // A new cycle may only start once the previous one has dropped, giving the one-cycle gap
    assign w_start     = w_bus_state & ~r_cyc;
    assign w_ack       = r_cyc & wbm_ack_i;
    assign w_tmo       = r_cyc & ~wbm_ack_i & (r_tmo == TIMEOUT - 16'd1);
    assign w_rd_busy   = wbm_dat_i[8];
    assign w_unused    = &{1'b0, wbm_dat_i[31:9]};

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = {4{r_cyc}};
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign rx_data   = r_rx_data;
    assign err       = r_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (cmd_txlen == 8'd0 && cmd_rxlen == 8'd0) w_next = S_DONE;
                else                                        w_next = S_CFG_ON;
            end
            S_CFG_ON:  if (w_ack) w_next = S_TX_GET;
            S_TX_GET: begin
                if (w_tx_more) begin
                    if (tx_valid) w_next = S_TX_WR;
                end else if (w_rx_more) begin
                    w_next = S_TX_WR;
                end else begin
                    w_next = S_CFG_OFF;
                end
            end
            S_TX_WR:   if (w_ack) w_next = S_POLL;
            S_POLL:    if (w_ack && !w_rd_busy) w_next = w_tx_more ? S_TX_GET : S_RX_PUT;
            S_RX_PUT:  if (rx_ready) w_next = S_TX_GET;
            S_CFG_OFF: if (w_ack) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        // Timeout abandons the command without releasing CSB
        if (w_tmo) w_next = S_IDLE;
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE) & r_live;
        busy      = (r_state != S_IDLE);
        tx_ready  = (r_state == S_TX_GET) & w_tx_more;
        rx_valid  = (r_state == S_RX_PUT);
        w_req_we  = 1'b0;
        w_req_adr = 32'd0;
        w_req_dat = 32'd0;
        case (r_state)
            S_CFG_ON: begin
                w_req_we  = 1'b1;
                w_req_adr = BASE_ADR + CFG_OFS;
                w_req_dat = {16'd0, 2'b00, 1'b1, 1'b1, 4'd0, PRESCALE};
            end
            S_TX_WR: begin
                w_req_we  = 1'b1;
                w_req_adr = BASE_ADR + DATA_OFS;
                w_req_dat = {24'd0, r_byte};
            end
            S_POLL: begin
                w_req_adr = BASE_ADR + DATA_OFS;
            end
            S_CFG_OFF: begin
                w_req_we  = 1'b1;
                w_req_adr = BASE_ADR + CFG_OFS;
                w_req_dat = {16'd0, 2'b00, 1'b1, 1'b0, 4'd0, PRESCALE};
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_live    <= 1'b0;
            r_txlen   <= 8'd0;
            r_rxlen   <= 8'd0;
            r_tx_cnt  <= 8'd0;
            r_rx_cnt  <= 8'd0;
            r_byte    <= 8'd0;
            r_rx_data <= 8'd0;
            r_err     <= 1'b0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_tmo     <= 16'd0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_txlen  <= cmd_txlen;
                r_rxlen  <= cmd_rxlen;
                r_tx_cnt <= 8'd0;
                r_rx_cnt <= 8'd0;
                r_err    <= 1'b0;
            end
            // In the rx phase a dummy zero byte clocks the slave
            if (r_state == S_TX_GET) r_byte <= w_tx_more ? tx_data : 8'h00;
            if (r_state == S_POLL && w_ack && !w_rd_busy) begin
                if (w_tx_more) r_tx_cnt  <= r_tx_cnt + 8'd1;
                else           r_rx_data <= wbm_dat_i[7:0];
            end
            if (r_state == S_RX_PUT && rx_ready) r_rx_cnt <= r_rx_cnt + 8'd1;
            if (w_start) begin
                r_cyc <= 1'b1;
                r_we  <= w_req_we;
                r_adr <= w_req_adr;
                r_dat <= w_req_dat;
                r_tmo <= 16'd0;
            end else if (w_ack || w_tmo) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
                r_adr <= 32'd0;
                r_dat <= 32'd0;
                if (w_tmo) r_err <= 1'b1;
            end else if (r_cyc) begin
                r_tmo <= r_tmo + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// tb/tb_spi_wb_sequencer.sv - Self-checking bench for spi_wb_sequencer with an SPI slave model
module tb_spi_wb_sequencer;

    localparam logic [31:0] CFG_A  = 32'h2400_0000;
    localparam logic [31:0] DATA_A = 32'h2400_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_txlen, cmd_rxlen;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        busy, err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    always #5 clk = ~clk;

    spi_wb_sequencer dut (
        .wb_clk_i (clk),       .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_txlen(cmd_txlen), .cmd_rxlen(cmd_rxlen),
        .tx_data  (tx_data),   .tx_valid (tx_valid),  .tx_ready(tx_ready),
        .rx_data  (rx_data),   .rx_valid (rx_valid),  .rx_ready(rx_ready),
        .busy     (busy),      .err      (err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    int         checks = 0;
    int         errors = 0;
    bus_t       bus_log[$];
    bus_t       exp_bus[$];
    logic [7:0] rx_got[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] rx_plan[$];
    int         s_busy_q[$];
    logic [7:0] s_rx_q[$];
    int         tx_hs = 0;
    bit         s_noack = 1'b0;
    int         s_dly = 0;
    int         s_busy_left = 0;
    logic [7:0] s_cur = 8'h00;
    logic [7:0] s_pend = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master slave model: random ack delay, busy for a planned number of reads per byte
    always @(negedge clk) begin
        wbm_ack_i = 1'b0;
        if (!rst_n) begin
            s_dly       = 0;
            s_busy_left = 0;
        end else if (wbm_cyc_o && wbm_stb_o && !s_noack) begin
            if (s_dly == 0) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) begin
                    if (wbm_adr_o == DATA_A) begin
                        s_pend      = (s_rx_q.size() > 0) ? s_rx_q.pop_front() : 8'h00;
                        s_busy_left = (s_busy_q.size() > 0) ? s_busy_q.pop_front() : 0;
                    end
                    bus_log.push_back(bus_t'{1'b1, wbm_adr_o, wbm_dat_o});
                end else begin
                    if (s_busy_left > 0) begin
                        s_busy_left--;
                        wbm_dat_i = {23'd0, 1'b1, s_cur};
                    end else begin
                        s_cur     = s_pend;
                        wbm_dat_i = {23'd0, 1'b0, s_cur};
                    end
                    bus_log.push_back(bus_t'{1'b0, wbm_adr_o, 32'd0});
                end
                s_dly = $urandom_range(0, 2);
            end else begin
                s_dly--;
            end
        end
    end

    logic        m_cyc, m_ack, m_we, m_rxv, m_rxr;
    logic [31:0] m_adr, m_dat;
    logic [7:0]  m_rxd;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cyc = 1'b0; m_ack = 1'b0; m_rxv = 1'b0; m_rxr = 1'b0;
        end else begin
            if (tx_valid && tx_ready) tx_hs++;
            if (rx_valid && rx_ready) rx_got.push_back(rx_data);
            if (wbm_cyc_o) chk("sel_stb", 32'({wbm_sel_o, wbm_stb_o}), 32'h1F);
            if (m_cyc && !m_ack && wbm_cyc_o) begin
                chk("bus_stable_adr", wbm_adr_o, m_adr);
                chk("bus_stable_dat", wbm_dat_o, m_dat);
                chk("bus_stable_we", 32'(wbm_we_o), 32'(m_we));
            end
            if (m_cyc && m_ack) chk("gap_after_ack", 32'(wbm_cyc_o), 0);
            if (rx_valid) chk("no_bus_during_rx", 32'(wbm_cyc_o), 0);
            if (m_rxv && !m_rxr) begin
                chk("rx_valid_held", 32'(rx_valid), 1);
                chk("rx_data_held", 32'(rx_data), 32'(m_rxd));
            end
            m_cyc = wbm_cyc_o; m_ack = wbm_ack_i; m_we = wbm_we_o;
            m_adr = wbm_adr_o; m_dat = wbm_dat_o;
            m_rxv = rx_valid;  m_rxr = rx_ready;  m_rxd = rx_data;
        end
    end

    task automatic run_cmd(input int txlen, input int rxlen, input int busy_fix, input bit hold_rx);
        int total, b, f_n, f_cnt, c_cnt, w_cnt;
        bit held;
        total = txlen + rxlen;
        bus_log.delete(); exp_bus.delete(); rx_got.delete(); exp_rx.delete();
        s_busy_q.delete(); s_rx_q.delete();
        while (tx_bytes.size() < txlen) tx_bytes.push_back(8'($urandom));
        while (rx_plan.size() < total) rx_plan.push_back(8'($urandom));
        if (total > 0) exp_bus.push_back(bus_t'{1'b1, CFG_A, 32'h0000_3002});
        for (int i = 0; i < total; i++) begin
            b = (busy_fix >= 0) ? busy_fix : int'($urandom_range(0, 4));
            s_busy_q.push_back(b);
            s_rx_q.push_back(rx_plan[i]);
            exp_bus.push_back(bus_t'{1'b1, DATA_A, {24'd0, (i < txlen) ? tx_bytes[i] : 8'h00}});
            for (int k = 0; k <= b; k++) exp_bus.push_back(bus_t'{1'b0, DATA_A, 32'd0});
            if (i >= txlen) exp_rx.push_back(rx_plan[i]);
        end
        if (total > 0) exp_bus.push_back(bus_t'{1'b1, CFG_A, 32'h0000_2002});

        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_txlen = 8'(txlen); cmd_rxlen = 8'(rxlen);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_txlen = 8'($urandom); cmd_rxlen = 8'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
        chk("err_clear_on_accept", 32'(err), 0);
        fork
            begin
                for (int i = 0; i < txlen; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    tx_valid = 1'b1; tx_data = tx_bytes[i];
                    f_n = tx_hs; f_cnt = 0;
                    while (tx_hs == f_n && f_cnt < 5000) begin @(negedge clk); f_cnt++; end
                    if (tx_hs == f_n) chk("tx_take_timeout", 32'(tx_hs), 32'(f_n + 1));
                    tx_valid = 1'b0; tx_data = 8'($urandom);
                end
            end
            begin
                c_cnt = 0; held = 1'b0;
                while (rx_got.size() < rxlen && c_cnt < 20000) begin
                    @(negedge clk); c_cnt++;
                    if (hold_rx && !held && rx_valid) begin
                        rx_ready = 1'b0;
                        repeat (20) @(negedge clk);
                        chk("rx_hold_valid", 32'(rx_valid), 1);
                        chk("rx_hold_data", 32'(rx_data), 32'(exp_rx[0]));
                        held = 1'b1; rx_ready = 1'b1;
                    end else if (!hold_rx || held) begin
                        rx_ready = 1'($urandom_range(0, 1));
                    end else begin
                        rx_ready = 1'b0;
                    end
                end
                rx_ready = 1'b0;
                chk("rx_all_taken", 32'(rx_got.size()), 32'(rxlen));
            end
        join
        w_cnt = 0;
        while (busy !== 1'b0 && w_cnt < 20000) begin @(negedge clk); w_cnt++; end
        chk("cmd_complete", 32'(busy), 0);
        chk("bus_count", 32'(bus_log.size()), 32'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
            chk($sformatf("bus%0d_we", i), 32'(bus_log[i].we), 32'(exp_bus[i].we));
            chk($sformatf("bus%0d_adr", i), bus_log[i].adr, exp_bus[i].adr);
            chk($sformatf("bus%0d_dat", i), bus_log[i].dat, exp_bus[i].dat);
        end
        chk("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
            chk($sformatf("rx%0d_data", i), 32'(rx_got[i]), 32'(exp_rx[i]));
        tx_bytes.delete(); rx_plan.delete();
    endtask

    int cnt, n;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_txlen = 8'd0; cmd_rxlen = 8'd0;
        tx_data = 8'd0; tx_valid = 1'b0; rx_ready = 1'b0;
        wbm_dat_i = 32'd0; wbm_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        tx_bytes = '{8'hA5, 8'h3C};
        run_cmd(2, 0, -1, 1'b0);

        tx_bytes = '{8'h9F};
        rx_plan  = '{8'h5A, 8'hEF, 8'h40, 8'h18};
        run_cmd(1, 3, -1, 1'b0);

        run_cmd(2, 1, 5, 1'b0);
        run_cmd(0, 2, -1, 1'b1);
        run_cmd(0, 0, -1, 1'b0);
        for (int r = 0; r < 4; r++) run_cmd($urandom_range(0, 4), $urandom_range(0, 4), -1, 1'b0);

        s_noack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_txlen = 8'd1; cmd_rxlen = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0; cnt = 0;
        while (cnt < 3000) begin
            @(negedge clk); cnt++;
            if (wbm_cyc_o) n++;
            else if (n > 0) break;
        end
        chk("timeout_cycles", 32'(n), 32'd1023);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_idle", 32'(busy), 0);
        chk("timeout_cmd_ready", 32'(cmd_ready), 1);
        s_noack = 1'b0;
        run_cmd(1, 1, -1, 1'b0);

        run_cmd(1, 255, 0, 1'b0);

        s_busy_q.delete(); s_rx_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_txlen = 8'd3; cmd_rxlen = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
        cnt = 0;
        while (!wbm_cyc_o && cnt < 100) begin @(negedge clk); cnt++; end
        chk("midcmd_cyc_seen", 32'(wbm_cyc_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", 32'(wbm_cyc_o), 0);
        chk("midrst_stb", 32'(wbm_stb_o), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rx_valid", 32'(rx_valid), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 0);
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_rel_busy", 32'(busy), 0);
        run_cmd(2, 2, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
